// File: rtl/decode_queue_pkg.sv
// Shared CPU decode definitions: opcode constants, instruction format encoding
// and the per-entry decode metadata stored alongside each queued instruction.
package decode_queue_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_U = 7'b0110111;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2,
        FMT_U = 2'd3
    } fmt_e;

    typedef struct packed {
        fmt_e fmt;
        logic illegal;
    } dec_meta_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface decode_queue_if
    import decode_queue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) ();

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [1:0]      out_fmt;
    logic            out_illegal;

    // The queue itself
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

    // The surrounding fetch/issue environment
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

endinterface

// File: rtl/decode_queue_imm_decode.sv
// Combinational immediate and format extraction for one raw instruction word.
module imm_decode
    import decode_queue_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm_c,
    output fmt_e            fmt_c,
    output logic            illegal_c
);

    // Unknown opcodes still decode to a zero R-type shape so the entry is well defined
    always_comb begin
        imm_c     = '0;
        fmt_c     = FMT_R;
        illegal_c = 1'b0;
        case (instr[6:0])
            OPC_R: ;
            OPC_I: begin
                fmt_c = FMT_I;
                imm_c = XLEN'($signed(instr[31:20]));
            end
            OPC_S: begin
                fmt_c = FMT_S;
                imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_U: begin
                fmt_c = FMT_U;
                imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and rename; immediates are decoded
// on the way in so the head entry presents a fully extended operand.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = XLEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    decode_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] instr_d [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] pc_d    [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [XLEN-1:0] imm_d   [DEPTH];
    dec_meta_t       meta_q  [DEPTH];
    dec_meta_t       meta_d  [DEPTH];

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            enq_c;
    logic            deq_c;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .instr     (bus.in_instr),
        .imm_c     (dec_imm),
        .fmt_c     (dec_fmt),
        .illegal_c (dec_illegal)
    );

    // Readiness depends only on occupancy, never on out_ready
    assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);

    // Flush squashes any handshake presented alongside it
    assign enq_c = bus.in_valid  && bus.in_ready  && !flush;
    assign deq_c = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        meta_d   = meta_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_c) begin
                instr_d[wr_ptr_q] = bus.in_instr;
                pc_d[wr_ptr_q]    = bus.in_pc;
                imm_d[wr_ptr_q]   = dec_imm;
                meta_d[wr_ptr_q]  = '{fmt: dec_fmt, illegal: dec_illegal};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is zeroed on reset so the head view reads as all-zero afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                imm_q[i]   <= '0;
                meta_q[i]  <= '{fmt: FMT_R, illegal: 1'b0};
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            meta_q   <= meta_d;
        end
    end

    assign bus.out_instr   = instr_q[rd_ptr_q];
    assign bus.out_pc      = pc_q[rd_ptr_q];
    assign bus.out_imm     = imm_q[rd_ptr_q];
    assign bus.out_fmt     = meta_q[rd_ptr_q].fmt;
    assign bus.out_illegal = meta_q[rd_ptr_q].illegal;
    assign count           = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: a negedge monitor predicts handshakes
// from its own occupancy model and queues expected/observed head entries.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [1:0]  fmt;
        logic        ill;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    decode_queue_if #(.XLEN(32)) bus ();

    decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    rec_t exp_q[$];
    rec_t want_q[$];
    rec_t got_q[$];
    int   mdl_count = 0;
    int   checks    = 0;
    int   failures  = 0;

    function automatic rec_t ref_entry(input logic [31:0] i, input logic [31:0] p);
        rec_t r;
        r.vld   = 1'b1;
        r.instr = i;
        r.pc    = p;
        r.imm   = 32'h0;
        r.fmt   = 2'd0;
        r.ill   = 1'b0;
        case (i[6:0])
            7'h33: ;
            7'h13: begin r.fmt = 2'd1; r.imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin r.fmt = 2'd2; r.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h37: begin r.fmt = 2'd3; r.imm = {i[31:12], 12'h000}; end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Inputs are stable at the falling edge; predict what the next rising edge does
    always @(negedge clk) begin : monitor
        logic enq, deq;
        rec_t w, g;
        if (rst || flush) begin
            exp_q.delete();
            mdl_count = 0;
        end else begin
            deq = (mdl_count != 0) && bus.out_ready;
            enq = bus.in_valid && (mdl_count != DEPTH);
            if (deq) begin
                if (exp_q.size() > 0) w = exp_q.pop_front();
                else                  w = 'x;
                g = '{vld: bus.out_valid, instr: bus.out_instr, pc: bus.out_pc,
                      imm: bus.out_imm, fmt: bus.out_fmt, ill: bus.out_illegal};
                want_q.push_back(w);
                got_q.push_back(g);
            end
            if (enq) exp_q.push_back(ref_entry(bus.in_instr, bus.in_pc));
            mdl_count = mdl_count + int'(enq) - int'(deq);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        bus.in_valid = 1'b1;
        bus.in_instr = i;
        bus.in_pc    = p;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opc [5];
        opc[0] = 7'h33; opc[1] = 7'h13; opc[2] = 7'h23; opc[3] = 7'h37; opc[4] = 7'h6F;
        w      = $urandom();
        w[6:0] = opc[$urandom_range(0, 4)];
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if ({bus.out_imm, bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal} !== '0) begin
            failures++;
            $display("FAIL reset_head: got imm=%h instr=%h pc=%h fmt=%0d ill=%b want all zero",
                     bus.out_imm, bus.out_instr, bus.out_pc, bus.out_fmt, bus.out_illegal);
        end
    endtask

    task automatic test_addi();
        rec_t g, w;
        offer(32'hFFF0_0093, 32'h0000_0100);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL addi_no_fallthrough: got out_valid=%b want 0", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addi_imm: got %h want ffffffff", bus.out_imm); end
        checks++; if (bus.out_fmt !== 2'd1) begin failures++; $display("FAIL addi_fmt: got %0d want 1", bus.out_fmt); end
        checks++; if (bus.out_illegal !== 1'b0) begin failures++; $display("FAIL addi_illegal: got %b want 0", bus.out_illegal); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL addi_scoreboard: got %h want %h", g, w); end
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL addi_empty: got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_sw_lui();
        rec_t g, w;
        offer(32'hFE11_2E23, 32'h0000_0200); tick();
        offer(32'h1234_52B7, 32'h0000_0204); tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL sw_lui_count: got %0d want 2", count); end
        checks++; if (bus.out_instr !== 32'hFE11_2E23) begin failures++; $display("FAIL sw_hold_instr: got %h want fe112e23", bus.out_instr); end
        checks++; if (bus.out_imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL sw_imm: got %h want fffffffc", bus.out_imm); end
        checks++; if (bus.out_fmt !== 2'd2) begin failures++; $display("FAIL sw_fmt: got %0d want 2", bus.out_fmt); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_imm !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm: got %h want 12345000", bus.out_imm); end
        checks++; if (bus.out_fmt !== 2'd3) begin failures++; $display("FAIL lui_fmt: got %0d want 3", bus.out_fmt); end
        checks++; if (bus.out_pc !== 32'h0000_0204) begin failures++; $display("FAIL lui_pc: got %h want 00000204", bus.out_pc); end
        tick();
        bus.out_ready = 1'b0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL sw_lui_scoreboard: got %h want %h", g, w); end
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sw_lui_empty: got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_full_wrap();
        rec_t g, w;
        int   budget;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(rand_instr(), 32'h1000 + 32'(i * 4)); tick();
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        offer(32'hDEAD_0013, 32'h0000_1010); tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_fifth_rejected: got count=%0d want 4", count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(rand_instr(), 32'h2000 + 32'(i * 4)); tick();
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL wrap_steady_count: got %0d want 3", count); end
        bus.in_valid = 1'b0;
        budget = 0;
        while (bus.out_valid === 1'b1 && budget < 20) begin tick(); budget++; end
        bus.out_ready = 1'b0;
        checks++; if (budget >= 20) begin failures++; $display("FAIL wrap_drain_timeout: got %0d cycles want < 20", budget); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL wrap_scoreboard: got %h want %h", g, w); end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_leftover: got %0d entries want 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        rec_t g, w;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(rand_instr(), 32'h3000 + 32'(i * 4)); tick();
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1; bus.out_ready = 1'b1;
        offer(32'hBAD0_0013, 32'h0000_BAD0);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        offer(32'h0010_0093, 32'h0000_3100); tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        bus.out_ready = 1'b0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL flush_scoreboard: got %h want %h", g, w); end
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_drained: got out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        rec_t g, w;
        offer(32'h0000_006F, 32'h0000_4000); tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_illegal !== 1'b1) begin failures++; $display("FAIL jal_illegal: got %b want 1", bus.out_illegal); end
        checks++; if (bus.out_imm !== 32'h0) begin failures++; $display("FAIL jal_imm: got %h want 00000000", bus.out_imm); end
        checks++; if (bus.out_fmt !== 2'd0) begin failures++; $display("FAIL jal_fmt: got %0d want 0", bus.out_fmt); end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL jal_scoreboard: got %h want %h", g, w); end
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        offer(32'h0020_0113, 32'h0000_5000); tick();
        offer(32'h0030_0193, 32'h0000_5004); tick();
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL rst_mid_pre_count: got %0d want 2", count); end
        rst = 1'b1;
        offer(32'h0040_0213, 32'h0000_5008); tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_imm !== 32'h0) begin failures++; $display("FAIL rst_mid_imm: got %h want 00000000", bus.out_imm); end
    endtask

    task automatic test_back_to_back();
        rec_t g, w;
        int   budget;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = rand_instr();
            bus.in_pc     = 32'h6000 + 32'(i * 4);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++; if (count !== 3'(mdl_count)) begin failures++; $display("FAIL b2b_count: got %0d want %0d", count, mdl_count); end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        budget = 0;
        while (bus.out_valid === 1'b1 && budget < 20) begin tick(); budget++; end
        bus.out_ready = 1'b0;
        checks++; if (budget >= 20) begin failures++; $display("FAIL b2b_drain_timeout: got %0d cycles want < 20", budget); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); checks++;
            if (g !== w) begin failures++; $display("FAIL b2b_scoreboard: got %h want %h", g, w); end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover: got %0d entries want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sw_lui();
        test_full_wrap();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want completion");
        $fatal(1);
    end

endmodule
